// File: rtl/pg_carry_resolve.sv
// Iterative Kogge-Stone carry resolution for the ALU adder, one prefix level per clock.
// Define PG_RESOLVE_TWO_LEVEL_EN to chain two prefix levels per clock.
`timescale 1ns/1ps
module pg_carry_resolve #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] p,
   input  logic [WIDTH-1:0] g,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N   = WIDTH + 1;
   localparam int LV  = $clog2(N);
   localparam int LVW = $clog2(LV + 3);
`ifdef PG_RESOLVE_TWO_LEVEL_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif

   typedef enum logic [1:0] {
      IDLE,
      PREFIX,
      DONE
   } state_t;

   state_t           state_q;
   logic [LVW-1:0]   lv_q;
   logic [N-1:0]     gw_q, pw_q;
   logic [N-1:0]     gw_d, pw_d;
   logic [N-1:0]     g1, p1;
   logic [WIDTH-1:0] p_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q, ovf_q, out_valid_q;
   logic [31:0]      sh0;
   logic             last;
`ifdef PG_RESOLVE_TWO_LEVEL_EN
   logic [31:0]      sh1;
   logic [N-1:0]     g2, p2;
`endif

   // Shifting by d leaves zeros below d, so low G bits stay put; the low
   // mask keeps the matching P bits unchanged as well.
   always_comb begin
      sh0 = 32'd1 << lv_q;
      g1  = gw_q | (pw_q & (gw_q << sh0));
      p1  = pw_q & ((pw_q << sh0) | ((N'(1) << sh0) - N'(1)));
`ifdef PG_RESOLVE_TWO_LEVEL_EN
      sh1 = sh0 << 1;
      g2  = g1 | (p1 & (g1 << sh1));
      p2  = p1 & ((p1 << sh1) | ((N'(1) << sh1) - N'(1)));
      if (int'(lv_q) + 1 < LV) begin
         gw_d = g2;
         pw_d = p2;
      end else begin
         gw_d = g1;
         pw_d = p1;
      end
      last = (int'(lv_q) + 2 >= LV);
`else
      gw_d = g1;
      pw_d = p1;
      last = (int'(lv_q) == LV - 1);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lv_q        <= '0;
         gw_q        <= '0;
         pw_q        <= '0;
         p_q         <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  p_q     <= p;
                  gw_q    <= {g, cin};
                  pw_q    <= {p, 1'b0};
                  lv_q    <= '0;
                  state_q <= PREFIX;
               end
            end
            PREFIX: begin
               gw_q <= gw_d;
               pw_q <= pw_d;
               lv_q <= lv_q + LVW'(STEP);
               if (last) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  sum_q       <= p_q ^ gw_d[WIDTH-1:0];
                  cout_q      <= gw_d[WIDTH];
                  ovf_q       <= gw_d[WIDTH-1] ^ gw_d[WIDTH];
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = rst_n & (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pg_carry_resolve.sv
// Self-checking bench for pg_carry_resolve against an a+b+cin reference.
`timescale 1ns/1ps
module tb_pg_carry_resolve;

   localparam int W = 17;
`ifdef PG_RESOLVE_TWO_LEVEL_EN
   localparam int LAT = 3;
   localparam int RST_EDGES = 1;
`else
   localparam int LAT = 5;
   localparam int RST_EDGES = 2;
`endif

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] p;
   logic [W-1:0] g;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int tests = 0;
   int fails = 0;

   pg_carry_resolve #(.WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .p(p),
      .g(g),
      .cin(cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum(sum),
      .cout(cout),
      .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {cout, ovf, sum} of a + b + c in two's complement.
   function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic c);
      logic [W:0]   t;
      logic [W-1:0] s;
      logic         ov;
      t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      s  = t[W-1:0];
      ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      return {t[W], ov, s};
   endfunction

   // Present an operation from a post-edge point; returns edges to out_valid.
   task automatic issue(input logic [W-1:0] pp, input logic [W-1:0] gg,
                        input logic cc, output int lat);
      int k;
      p = pp;
      g = gg;
      cin = cc;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      p = W'($urandom);
      g = W'($urandom);
      cin = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      p = '0;
      g = '0;
      cin = 1'b0;
      #1;
      tests++;
      if ({in_ready, out_valid, cout, ovf, sum} !== '0) begin
         fails++;
         $display("FAIL reset_state: got rdy=%b ov=%b sum=%h co=%b ovf=%b want all 0",
                  in_ready, out_valid, sum, cout, ovf);
      end
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] tp[5] = '{17'h00006, 17'h1FFFE, 17'h0FFFE, 17'h1FFFF, 17'h1FFFF};
      logic [W-1:0] tg[5] = '{17'h00001, 17'h00001, 17'h00001, 17'h00000, 17'h00000};
      logic         tc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [W+1:0] te[5] = '{{2'b00, 17'h00008}, {2'b10, 17'h00000},
                              {2'b01, 17'h10000}, {2'b10, 17'h00000},
                              {2'b00, 17'h1FFFF}};
      int lat;
      for (int i = 0; i < 5; i++) begin
         issue(tp[i], tg[i], tc[i], lat);
         tests++;
         if (lat !== LAT) begin
            fails++;
            $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, LAT);
         end
         tests++;
         if ({cout, ovf, sum} !== te[i]) begin
            fails++;
            $display("FAIL directed_result[%0d]: got co=%b ovf=%b sum=%h want co=%b ovf=%b sum=%h",
                     i, cout, ovf, sum, te[i][W+1], te[i][W], te[i][W-1:0]);
         end
         take();
         tests++;
         if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL directed_take[%0d]: got valid=%b ready=%b want valid=0 ready=1",
                     i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W+1:0] snap, exp1, exp2;
      logic [W-1:0] a2, b2;
      int lat;
      exp1 = model(17'h00523, 17'h00400, 1'b1);
      issue(17'h00123, 17'h00400, 1'b1, lat);
      snap = {cout, ovf, sum};
      tests++;
      if (snap !== exp1) begin
         fails++;
         $display("FAIL bp_first_result: got %h want %h", snap, exp1);
      end
      a2 = 17'h1A5C3;
      b2 = 17'h0F0F1;
      exp2 = model(a2, b2, 1'b0);
      p = a2 ^ b2;
      g = a2 & b2;
      cin = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         tests++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || {cout, ovf, sum} !== snap) begin
            fails++;
            $display("FAIL bp_hold[%0d]: got rdy=%b valid=%b res=%h want rdy=0 valid=1 res=%h",
                     i, in_ready, out_valid, {cout, ovf, sum}, snap);
         end
      end
      take();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_take: got valid=%b rdy=%b want valid=0 rdy=1", out_valid, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      tests++;
      if (lat !== LAT || {cout, ovf, sum} !== exp2) begin
         fails++;
         $display("FAIL bp_second_op: got lat=%0d res=%h want lat=%0d res=%h",
                  lat, {cout, ovf, sum}, LAT, exp2);
      end
      take();
   endtask

   task automatic test_reset_midprefix();
      bit seen;
      p = 17'h0F0F0;
      g = 17'h00F0F;
      cin = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (RST_EDGES) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({in_ready, out_valid, cout, ovf, sum} !== '0) begin
         fails++;
         $display("FAIL midprefix_reset: got rdy=%b valid=%b sum=%h co=%b ovf=%b want all 0",
                  in_ready, out_valid, sum, cout, ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL midprefix_ready: got %b want 1", in_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      tests++;
      if (seen !== 1'b0) begin
         fails++;
         $display("FAIL midprefix_stale_valid: got 1 want 0");
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      logic         c;
      logic [W+1:0] exp;
      int lat;
      for (int i = 0; i < 10000; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         c = 1'($urandom);
         exp = model(a, b, c);
         issue(a ^ b, a & b, c, lat);
         tests++;
         if (lat !== LAT || {cout, ovf, sum} !== exp) begin
            fails++;
            $display("FAIL random[%0d] a=%h b=%h c=%b: got lat=%0d res=%h want lat=%0d res=%h",
                     i, a, b, c, lat, {cout, ovf, sum}, LAT, exp);
         end
         take();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_midprefix();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
